// File: rtl/jk_bank_ctrl_if.sv
// rtl/jk_bank_ctrl_if.sv - command/JK-drive bundle between a command source and jk_bank_ctrl
//
// Purpose: groups the command handshake, the registered J/K bank drive and the
//          status outputs of jk_bank_ctrl into one bundle.
// Signals:
//   cmd_valid, cmd_op[2:0], cmd_data[WIDTH], cmd_amt[CNT_W]  source -> controller
//   cmd_ready, j[WIDTH], k[WIDTH], q_mirror[WIDTH], busy, done  controller -> source/bank
// Modports: master (command source / bench), slave (controller).
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_mirror;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_amt,
        input  cmd_ready, j, k, q_mirror, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_amt,
        output cmd_ready, j, k, q_mirror, busy, done
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command sequencer driving the j/k inputs of a JK flip-flop bank
//
// Purpose: turns LOAD / CLEAR / SET / TOGGLE / SHL / SHR / ROTL commands into
//          registered per-cycle J/K pairs for WIDTH JK cells, keeps q_mirror as a
//          cycle-exact copy of the bank q and pulses done when a result is in place.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    jk_bank_ctrl_if.slave: command handshake, j/k drive, q_mirror, busy, done
module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    jk_bank_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_SET    = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_SHL    = 3'b101;
    localparam logic [2:0] OP_SHR    = 3'b110;
    localparam logic [2:0] OP_ROTL   = 3'b111;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_rem;
    logic [2:0]       r_op;
    logic             r_last;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] w_k_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [2:0]       w_op_nxt;
    logic             w_last_nxt;
    logic [WIDTH-1:0] w_shadow;
    logic [WIDTH-1:0] w_step;
    logic             w_ready;
    logic             w_accept;

    // One-position move of the bank value; fill bits are zero except for ROTL.
    function automatic logic [WIDTH-1:0] f_step(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v);
        case (op)
            OP_SHL:  f_step = {v[WIDTH-2:0], 1'b0};
            OP_SHR:  f_step = {1'b0, v[WIDTH-1:1]};
            default: f_step = {v[WIDTH-2:0], v[WIDTH-1]};
        endcase
    endfunction

    // Value the bank will hold after the next edge: JK next-state of the
    // currently driven pair applied to the mirror. Commands build on this so
    // a command accepted right behind another sees its pending result.
    assign w_shadow = (r_j & ~r_q) | (~r_k & r_q);
    assign w_ready  = (r_state == S_IDLE);
    assign w_accept = w_ready && bus.cmd_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = '0;
        w_k_nxt     = '0;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_last_nxt  = 1'b0;
        w_step      = f_step(r_op, w_shadow);
        case (r_state)
            S_INIT: begin
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_last_nxt = 1'b1;
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            w_j_nxt = bus.cmd_data;
                            w_k_nxt = ~bus.cmd_data;
                        end
                        OP_CLEAR:  w_k_nxt = bus.cmd_data;
                        OP_SET:    w_j_nxt = bus.cmd_data;
                        OP_TOGGLE: begin
                            w_j_nxt = bus.cmd_data;
                            w_k_nxt = bus.cmd_data;
                        end
                        OP_SHL, OP_SHR, OP_ROTL: begin
                            // Amount 0 degenerates to a NOP with a done pulse.
                            if (bus.cmd_amt != '0) begin
                                w_step   = f_step(bus.cmd_op, w_shadow);
                                w_j_nxt  = w_step;
                                w_k_nxt  = ~w_step;
                                w_op_nxt = bus.cmd_op;
                                if (bus.cmd_amt != CNT_W'(1)) begin
                                    w_last_nxt  = 1'b0;
                                    w_state_nxt = S_SHIFT;
                                    w_rem_nxt   = bus.cmd_amt - CNT_W'(1);
                                end
                            end
                        end
                        default: ; // OP_NOP: j = k = 0
                    endcase
                end
            end
            S_SHIFT: begin
                w_j_nxt   = w_step;
                w_k_nxt   = ~w_step;
                w_rem_nxt = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Reset drives k to all ones so every edge under reset clears the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_j     <= '0;
            r_k     <= '1;
            r_q     <= '0;
            r_rem   <= '0;
            r_op    <= OP_NOP;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_q     <= w_shadow;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_last  <= w_last_nxt;
            // done lags the final j/k pair by one edge: that is the edge at
            // which the bank actually takes the final value.
            r_done  <= r_last;
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.busy      = ~w_ready;
    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.q_mirror  = r_q;
    assign bus.done      = r_done;
endmodule
